// File: rtl/usb_bit_strobe_gen.sv
// Bit-rate strobe generator: divides clk by div_int + div_frac/2^FRAC_W using a
// phase accumulator, with mid-bit strobe, RX phase resync and bit/byte position.
module usb_bit_strobe_gen #(
   parameter int CNT_W  = 5,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              enable,
   input  logic [CNT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              load,
   input  logic              resync,
   output logic              bit_en,
   output logic              half_en,
   output logic              byte_en,
   output logic [2:0]        bit_idx
);

   localparam int LW = CNT_W + 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  int_s;
   logic [CNT_W-1:0]  int_clamp;
   logic [CNT_W-1:0]  int_use;
   logic [FRAC_W-1:0] frac_s;
   logic [FRAC_W-1:0] frac_use;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0]   acc_sum;
   logic [LW-1:0]     cnt;
   logic [LW-1:0]     cur_len;
   logic [LW-1:0]     half_len;
   logic [LW-1:0]     len_nxt;
   logic              active;

   assign int_clamp = (div_int < CNT_W'(2)) ? CNT_W'(2) : div_int;

   // A load coinciding with a bit boundary already governs that boundary's length.
   assign int_use  = load ? int_clamp : int_s;
   assign frac_use = load ? div_frac  : frac_s;

   assign acc_sum  = {1'b0, acc} + {1'b0, frac_use};
   assign len_nxt  = {1'b0, int_use} + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};
   assign half_len = cur_len >> 1;

   assign active  = (state == RUN) && enable;
   assign bit_en  = active && (cnt == cur_len - LW'(1));
   assign half_en = active && (cnt == half_len - LW'(1)) && !resync;
   assign byte_en = bit_en && (bit_idx == 3'd7);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable)  state_nxt = RUN;
         RUN:     if (!enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt     <= '0;
         acc     <= '0;
         cur_len <= LW'(2);
         int_s   <= '0;
         frac_s  <= '0;
         bit_idx <= 3'd0;
      end else if (state == IDLE) begin
         if (enable) begin
            int_s   <= int_clamp;
            frac_s  <= div_frac;
            cur_len <= {1'b0, int_clamp};
            cnt     <= '0;
            acc     <= '0;
            bit_idx <= 3'd0;
         end
      end else if (!enable) begin
         cnt     <= '0;
         acc     <= '0;
         bit_idx <= 3'd0;
      end else begin
         if (load) begin
            int_s  <= int_clamp;
            frac_s <= div_frac;
         end
         if (bit_en) begin
            acc     <= acc_sum[FRAC_W-1:0];
            cur_len <= len_nxt;
            bit_idx <= bit_idx + 3'd1;
            // Resync on a boundary centres the phase within the newly computed bit.
            cnt     <= resync ? (len_nxt >> 1) : '0;
         end else begin
            cnt     <= resync ? half_len : cnt + LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_usb_bit_strobe_gen.sv
// Directed bench for usb_bit_strobe_gen: strobe spacing, fractional division,
// clamping, staged load, resync, enable drop and asynchronous reset.
module tb_usb_bit_strobe_gen;

   localparam int CNT_W  = 5;
   localparam int FRAC_W = 4;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              enable;
   logic [CNT_W-1:0]  div_int;
   logic [FRAC_W-1:0] div_frac;
   logic              load;
   logic              resync;
   logic              bit_en;
   logic              half_en;
   logic              byte_en;
   logic [2:0]        bit_idx;

   int n_assert = 0;
   int n_fail   = 0;
   int n_coinc  = 0;
   int n;
   int total;

   usb_bit_strobe_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .enable   (enable),
      .div_int  (div_int),
      .div_frac (div_frac),
      .load     (load),
      .resync   (resync),
      .bit_en   (bit_en),
      .half_en  (half_en),
      .byte_en  (byte_en),
      .bit_idx  (bit_idx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bit_en === 1'b1 && half_en === 1'b1) n_coinc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_bit(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (bit_en !== 1'b1 && cycles < 40);
   endtask

   task automatic wait_half(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (half_en !== 1'b1 && cycles < 40);
   endtask

   task automatic restart(input logic [CNT_W-1:0] di, input logic [FRAC_W-1:0] df);
      enable = 1'b0;
      tick();
      div_int  = di;
      div_frac = df;
      enable   = 1'b1;
   endtask

   initial begin
      n_rst    = 1'b0;
      enable   = 1'b0;
      div_int  = '0;
      div_frac = '0;
      load     = 1'b0;
      resync   = 1'b0;
      tick();
      tick();
      chk("rst_bit_en",  bit_en,  0);
      chk("rst_half_en", half_en, 0);
      chk("rst_byte_en", byte_en, 0);
      chk("rst_bit_idx", bit_idx, 0);

      // 8/0: integer division, half strobe, byte strobe
      n_rst   = 1'b1;
      div_int = 5'd8;
      enable  = 1'b1;
      wait_bit(n);
      chk("int_first_period", n, 8);
      chk("int_first_idx", bit_idx, 0);
      wait_half(n);
      chk("int_half_after_bit", n, 4);
      wait_bit(n);
      chk("int_half_to_bit", n, 4);
      chk("int_idx1", bit_idx, 1);
      for (int k = 2; k <= 7; k++) begin
         wait_bit(n);
         chk("int_period", n, 8);
         chk("int_idx", bit_idx, k);
         chk("int_byte_en", byte_en, (k == 7) ? 1 : 0);
      end
      tick();
      chk("int_idx_wrap", bit_idx, 0);

      // 8 + 8/16: alternating 8/9 spacing
      restart(5'd8, 4'd8);
      wait_bit(n);
      chk("frac_first_period", n, 8);
      total = 0;
      for (int k = 1; k <= 16; k++) begin
         wait_bit(n);
         chk("frac_interval", n, (k % 2 == 0) ? 9 : 8);
         total += n;
      end
      chk("frac_total_16", total, 136);

      // div_int=1 clamps to 2
      restart(5'd1, 4'd0);
      wait_bit(n);
      chk("clamp_first_period", n, 2);
      wait_half(n);
      chk("clamp_half_after_bit", n, 1);
      wait_bit(n);
      chk("clamp_half_to_bit", n, 1);
      wait_bit(n);
      chk("clamp_period", n, 2);

      // staged load mid-bit and coincident with bit_en
      restart(5'd8, 4'd0);
      wait_bit(n);
      chk("load_first_period", n, 8);
      repeat (3) tick();
      load    = 1'b1;
      div_int = 5'd6;
      tick();
      load = 1'b0;
      wait_bit(n);
      chk("load_current_bit", 4 + n, 8);
      wait_bit(n);
      chk("load_new_bit_a", n, 6);
      wait_bit(n);
      chk("load_new_bit_b", n, 6);
      tick();
      load    = 1'b1;
      div_int = 5'd8;
      tick();
      load = 1'b0;
      wait_bit(n);
      chk("load_back_current", 2 + n, 6);
      wait_bit(n);
      chk("load_back_to_8", n, 8);
      load    = 1'b1;
      div_int = 5'd6;
      tick();
      load = 1'b0;
      wait_bit(n);
      chk("load_coincident", 1 + n, 6);

      // resync at cnt==2, at cnt==3 (half suppressed), and on bit_en
      restart(5'd8, 4'd0);
      wait_bit(n);
      chk("resync_first_period", n, 8);
      repeat (3) tick();
      resync = 1'b1;
      tick();
      resync = 1'b0;
      wait_bit(n);
      chk("resync_cnt2", 1 + n, 4);
      chk("resync_idx1", bit_idx, 1);
      repeat (4) tick();
      chk("resync_half_pre", half_en, 1);
      resync = 1'b1;
      #1;
      chk("resync_half_suppressed", half_en, 0);
      tick();
      resync = 1'b0;
      wait_bit(n);
      chk("resync_cnt3", 1 + n, 4);
      chk("resync_idx2", bit_idx, 2);
      resync = 1'b1;
      #1;
      chk("resync_coinc_bit_en", bit_en, 1);
      tick();
      resync = 1'b0;
      chk("resync_coinc_idx", bit_idx, 3);
      wait_bit(n);
      chk("resync_coinc_period", 1 + n, 4);

      // enable dropped in the cnt==7 cycle
      repeat (8) tick();
      chk("drop_pre_bit_en", bit_en, 1);
      enable = 1'b0;
      #1;
      chk("drop_bit_en", bit_en, 0);
      chk("drop_half_en", half_en, 0);
      tick();
      chk("drop_idx", bit_idx, 0);
      chk("drop_idle_bit_en", bit_en, 0);
      enable = 1'b1;
      wait_bit(n);
      chk("drop_reenable_period", n, 8);

      // asynchronous reset while bit_en is high
      wait_bit(n);
      chk("arst_pre_period", n, 8);
      chk("arst_pre_idx", bit_idx, 1);
      n_rst = 1'b0;
      #1;
      chk("arst_bit_en", bit_en, 0);
      chk("arst_half_en", half_en, 0);
      chk("arst_byte_en", byte_en, 0);
      chk("arst_bit_idx", bit_idx, 0);
      enable = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
      tick();
      chk("arst_idle_bit_en", bit_en, 0);
      enable = 1'b1;
      wait_bit(n);
      chk("arst_restart_period", n, 8);

      chk("no_coincident_strobes", n_coinc, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
